// File: rtl/gcm_aes_host_ctrl_if.sv
// Host block stream into gcm_aes_host_ctrl: valid/ready transfer of 128-bit AAD or plaintext blocks.
interface gcm_aes_host_ctrl_if;
  logic         i_blk_valid;
  logic         o_blk_ready;
  logic [0:127] i_blk_data;
  logic         i_blk_is_aad;

  modport master (output i_blk_valid, i_blk_data, i_blk_is_aad, input o_blk_ready);
  modport slave  (input i_blk_valid, i_blk_data, i_blk_is_aad, output o_blk_ready);
endinterface

// File: rtl/gcm_aes_host_ctrl.sv
// Host-side sequencer for the gcm_aes core: turns a block stream into the
// new_instance/pt_instance pulse protocol and collects ciphertext and tag.
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | taking AAD block 0 (or skipping when there is no AAD)
// SETUP | o_new_instance held for key/H setup
// AAD   | AAD blocks 1..n-1, one per cycle, no gaps
// HWAIT | idle gap before the first plaintext block
// PT    | taking one plaintext block
// CPW   | waiting for the core's ciphertext
// TAGW  | waiting for the core's tag
module gcm_aes_host_ctrl #(
  parameter int NEW_HOLD = 3,
  parameter int H_WAIT   = 14,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [0:127]          i_key,
  input  logic [0:95]           i_iv,
  input  logic [63:0]           i_aad_bits,
  input  logic [63:0]           i_pt_bits,
  gcm_aes_host_ctrl_if.slave    blk,
  output logic                  o_ct_valid,
  output logic [0:127]          o_ct_data,
  output logic                  o_tag_valid,
  output logic [0:127]          o_tag,
  output logic                  o_busy,
  output logic                  o_error,
  output logic                  o_new_instance,
  output logic                  o_pt_instance,
  output logic [0:127]          o_cipher_key,
  output logic [0:95]           o_iv,
  output logic [0:127]          o_aad,
  output logic [0:127]          o_plain_text,
  output logic [63:0]           o_plain_text_size,
  output logic [63:0]           o_aad_size,
  input  logic [0:127]          i_cipher_text,
  input  logic [0:127]          i_tag,
  input  logic                  i_cp_ready,
  input  logic                  i_tag_ready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] AAD   = 3'd3;
  localparam logic [2:0] HWAIT = 3'd4;
  localparam logic [2:0] PT    = 3'd5;
  localparam logic [2:0] CPW   = 3'd6;
  localparam logic [2:0] TAGW  = 3'd7;

  localparam logic [15:0] NEW_LD = 16'(NEW_HOLD - 1);
  localparam logic [15:0] H_LD   = 16'(H_WAIT - 1);
  localparam logic [15:0] TO_LD  = 16'(TIMEOUT - 1);

  logic [2:0]   state;
  logic [15:0]  timer;
  logic [63:0]  aad_left;
  logic [63:0]  pt_left;
  logic [63:0]  n_aad;
  logic [63:0]  n_pt;
  logic         blk_ready;
  logic         accept;
  logic         last_pt;
  logic [6:0]   rem_bits;
  logic [0:127] ct_mask;

  // 65-bit add so an all-ones length still rounds up correctly
  assign n_aad = 64'(({1'b0, i_aad_bits} + 65'd127) >> 7);
  assign n_pt  = 64'(({1'b0, i_pt_bits} + 65'd127) >> 7);

  always_comb begin
    blk_ready = 1'b0;
    case (state)
      LOAD:    blk_ready = (aad_left != 64'd0);
      AAD, PT: blk_ready = 1'b1;
      default: blk_ready = 1'b0;
    endcase
  end

  assign blk.o_blk_ready = blk_ready;
  assign accept          = blk.i_blk_valid & blk_ready;
  assign o_busy          = (state != IDLE);
  assign o_new_instance  = (state == SETUP);
  assign last_pt         = (pt_left == 64'd1);
  assign rem_bits        = o_plain_text_size[6:0];
  // Index 0 is the first bit, so shifting right clears the tail of the block
  assign ct_mask = (last_pt && rem_bits != 7'd0) ? ~({128{1'b1}} >> rem_bits) : {128{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      timer             <= '0;
      aad_left          <= '0;
      pt_left           <= '0;
      o_ct_valid        <= 1'b0;
      o_ct_data         <= '0;
      o_tag_valid       <= 1'b0;
      o_tag             <= '0;
      o_error           <= 1'b0;
      o_pt_instance     <= 1'b0;
      o_cipher_key      <= '0;
      o_iv              <= '0;
      o_aad             <= '0;
      o_plain_text      <= '0;
      o_plain_text_size <= '0;
      o_aad_size        <= '0;
    end else begin
      o_pt_instance <= 1'b0;
      o_ct_valid    <= 1'b0;
      o_tag_valid   <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          o_cipher_key      <= i_key;
          o_iv              <= i_iv;
          o_aad_size        <= i_aad_bits;
          o_plain_text_size <= i_pt_bits;
          aad_left          <= n_aad;
          pt_left           <= n_pt;
          o_aad             <= '0;
          o_error           <= 1'b0;
          state             <= LOAD;
        end
        LOAD: if (aad_left == 64'd0) begin
          state <= SETUP;
          timer <= NEW_LD;
        end else if (accept) begin
          if (!blk.i_blk_is_aad) begin
            o_error <= 1'b1;
            state   <= IDLE;
          end else begin
            o_aad    <= blk.i_blk_data;
            aad_left <= aad_left - 64'd1;
            state    <= SETUP;
            timer    <= NEW_LD;
          end
        end
        SETUP: if (timer == 16'd0) begin
          state <= (aad_left != 64'd0) ? AAD : HWAIT;
          timer <= H_LD;
        end else begin
          timer <= timer - 16'd1;
        end
        AAD: if (!blk.i_blk_valid || !blk.i_blk_is_aad) begin
          o_error <= 1'b1;
          state   <= IDLE;
        end else begin
          o_aad    <= blk.i_blk_data;
          aad_left <= aad_left - 64'd1;
          if (aad_left == 64'd1) begin
            state <= HWAIT;
            timer <= H_LD;
          end
        end
        HWAIT: if (timer == 16'd0) begin
          state <= (pt_left != 64'd0) ? PT : TAGW;
          timer <= TO_LD;
        end else begin
          timer <= timer - 16'd1;
        end
        PT: if (accept) begin
          if (blk.i_blk_is_aad) begin
            o_error <= 1'b1;
            state   <= IDLE;
          end else begin
            o_plain_text  <= blk.i_blk_data;
            o_pt_instance <= 1'b1;
            state         <= CPW;
            timer         <= TO_LD;
          end
        end
        CPW: if (i_cp_ready) begin
          o_ct_data  <= i_cipher_text & ct_mask;
          o_ct_valid <= 1'b1;
          pt_left    <= pt_left - 64'd1;
          state      <= last_pt ? TAGW : PT;
          timer      <= TO_LD;
        end else if (timer == 16'd0) begin
          o_error <= 1'b1;
          state   <= IDLE;
        end else begin
          timer <= timer - 16'd1;
        end
        TAGW: if (i_tag_ready) begin
          o_tag       <= i_tag;
          o_tag_valid <= 1'b1;
          state       <= IDLE;
        end else if (timer == 16'd0) begin
          o_error <= 1'b1;
          state   <= IDLE;
        end else begin
          timer <= timer - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_aes_host_ctrl.sv
// Directed bench for gcm_aes_host_ctrl; the bench plays both the host and the gcm_aes core.
module tb_gcm_aes_host_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [0:127] i_key = '0;
  logic [0:95]  i_iv = '0;
  logic [63:0]  i_aad_bits = '0;
  logic [63:0]  i_pt_bits = '0;
  logic         o_ct_valid, o_tag_valid, o_busy, o_error, o_new_instance, o_pt_instance;
  logic [0:127] o_ct_data, o_tag, o_cipher_key, o_aad, o_plain_text;
  logic [0:95]  o_iv;
  logic [63:0]  o_plain_text_size, o_aad_size;
  logic [0:127] i_cipher_text = '0;
  logic [0:127] i_tag = '0;
  logic         i_cp_ready = 1'b0;
  logic         i_tag_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [127:0] CT0  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TAG0 = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MASK200 = 128'hFFFFFFFFFFFFFFFFFF00000000000000;

  gcm_aes_host_ctrl_if blk_if ();

  gcm_aes_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_key(i_key), .i_iv(i_iv),
    .i_aad_bits(i_aad_bits), .i_pt_bits(i_pt_bits), .blk(blk_if),
    .o_ct_valid(o_ct_valid), .o_ct_data(o_ct_data), .o_tag_valid(o_tag_valid), .o_tag(o_tag),
    .o_busy(o_busy), .o_error(o_error), .o_new_instance(o_new_instance),
    .o_pt_instance(o_pt_instance), .o_cipher_key(o_cipher_key), .o_iv(o_iv), .o_aad(o_aad),
    .o_plain_text(o_plain_text), .o_plain_text_size(o_plain_text_size), .o_aad_size(o_aad_size),
    .i_cipher_text(i_cipher_text), .i_tag(i_tag), .i_cp_ready(i_cp_ready), .i_tag_ready(i_tag_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 128'(|{blk_if.o_blk_ready, o_ct_valid, o_ct_data, o_tag_valid, o_tag, o_busy,
                      o_error, o_new_instance, o_pt_instance, o_cipher_key, o_iv, o_aad,
                      o_plain_text, o_plain_text_size, o_aad_size}), 128'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_op(input logic [63:0] aad, input logic [63:0] pt,
                          input logic [127:0] key, input logic [95:0] iv);
    i_start = 1'b1; i_aad_bits = aad; i_pt_bits = pt; i_key = key; i_iv = iv;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] d, input logic is_aad);
    blk_if.i_blk_valid = 1'b1; blk_if.i_blk_data = d; blk_if.i_blk_is_aad = is_aad;
  endtask

  // Zero-AAD, one plaintext block, known AES-GCM vector returned by the core
  task automatic run_single(input string p);
    start_op(64'd0, 64'd128, 128'd0, 96'd0);
    check({p, "_ni_c1"}, o_new_instance, 0);
    check({p, "_busy_c1"}, o_busy, 1);
    check({p, "_rdy_c1"}, blk_if.o_blk_ready, 0);
    tick(1); check({p, "_ni_c2"}, o_new_instance, 1); check({p, "_aad0"}, o_aad, 0);
    tick(1); check({p, "_ni_c3"}, o_new_instance, 1);
    tick(1); check({p, "_ni_c4"}, o_new_instance, 1);
    tick(1); check({p, "_ni_c5"}, o_new_instance, 0);
    tick(13); check({p, "_rdy_hwait"}, blk_if.o_blk_ready, 0);
    tick(1); check({p, "_rdy_pt"}, blk_if.o_blk_ready, 1);
    send_blk(128'd0, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check({p, "_pti"}, o_pt_instance, 1);
    check({p, "_ptxt"}, o_plain_text, 0);
    check({p, "_rdy_cpw"}, blk_if.o_blk_ready, 0);
    i_cp_ready = 1'b1; i_cipher_text = CT0;
    tick(1); i_cp_ready = 1'b0;
    check({p, "_ctv"}, o_ct_valid, 1);
    check({p, "_ct"}, o_ct_data, CT0);
    check({p, "_pti_off"}, o_pt_instance, 0);
    i_tag_ready = 1'b1; i_tag = TAG0;
    tick(1); i_tag_ready = 1'b0;
    check({p, "_tagv"}, o_tag_valid, 1);
    check({p, "_tag"}, o_tag, TAG0);
    check({p, "_idle"}, o_busy, 0);
    check({p, "_err"}, o_error, 0);
    tick(1); check({p, "_tagv_off"}, o_tag_valid, 0);
  endtask

  initial begin
    logic seen_ct;
    blk_if.i_blk_valid = 1'b0; blk_if.i_blk_data = '0; blk_if.i_blk_is_aad = 1'b0;
    tick(1);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick(1);
    check_all_zero("post_reset_idle");

    run_single("t1");

    // Four AAD blocks, two plaintext blocks
    start_op(64'd512, 64'd256, 128'h000102030405060708090a0b0c0d0e0f, 96'hcafebabefacedbaddecaf888);
    check("t2_rdy_load", blk_if.o_blk_ready, 1);
    check("t2_key", o_cipher_key, 128'h000102030405060708090a0b0c0d0e0f);
    check("t2_iv", o_iv, 96'hcafebabefacedbaddecaf888);
    send_blk(128'hA0, 1'b1);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check("t2_aad0", o_aad, 128'hA0);
    check("t2_ni", o_new_instance, 1);
    check("t2_rdy_setup", blk_if.o_blk_ready, 0);
    tick(3);
    check("t2_rdy_aad", blk_if.o_blk_ready, 1);
    check("t2_ni_end", o_new_instance, 0);
    send_blk(128'hA1, 1'b1);
    tick(1); check("t2_aad1", o_aad, 128'hA1); send_blk(128'hA2, 1'b1);
    tick(1); check("t2_aad2", o_aad, 128'hA2); send_blk(128'hA3, 1'b1);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check("t2_aad3", o_aad, 128'hA3);
    check("t2_rdy_hw", blk_if.o_blk_ready, 0);
    tick(2);
    i_start = 1'b1; i_aad_bits = 64'd999;
    tick(1); i_start = 1'b0; i_aad_bits = 64'd512;
    check("t2_start_ignored", o_aad_size, 64'd512);
    check("t2_ptsize", o_plain_text_size, 64'd256);
    tick(10); check("t2_rdy_hw_end", blk_if.o_blk_ready, 0);
    tick(1); check("t2_rdy_pt0", blk_if.o_blk_ready, 1);
    send_blk(128'hB0, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check("t2_pt0", o_plain_text, 128'hB0);
    i_cp_ready = 1'b1; i_cipher_text = 128'hC0;
    tick(1); i_cp_ready = 1'b0;
    check("t2_ctv0", o_ct_valid, 1);
    check("t2_ct0", o_ct_data, 128'hC0);
    send_blk(128'hB1, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check("t2_pt1", o_plain_text, 128'hB1);
    check("t2_ctv_gap", o_ct_valid, 0);
    i_cp_ready = 1'b1; i_cipher_text = 128'hC1;
    tick(1); i_cp_ready = 1'b0;
    check("t2_ct1", o_ct_data, 128'hC1);
    check("t2_tagv_early", o_tag_valid, 0);
    i_tag_ready = 1'b1; i_tag = 128'hD7;
    tick(1); i_tag_ready = 1'b0;
    check("t2_tagv", o_tag_valid, 1);
    check("t2_tag", o_tag, 128'hD7);
    check("t2_err", o_error, 0);
    tick(1);

    // 200 plaintext bits: the second block keeps only bits 0..71
    start_op(64'd0, 64'd200, 128'd1, 96'd1);
    tick(18);
    send_blk(128'h1, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    i_cp_ready = 1'b1; i_cipher_text = ONES;
    tick(1); i_cp_ready = 1'b0;
    check("t3_ct0_full", o_ct_data, ONES);
    check("t3_rdy_pt1", blk_if.o_blk_ready, 1);
    send_blk(128'h2, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    i_cp_ready = 1'b1;
    tick(1); i_cp_ready = 1'b0;
    check("t3_ctv1", o_ct_valid, 1);
    check("t3_ct1_masked", o_ct_data, MASK200);
    i_tag_ready = 1'b1;
    tick(1); i_tag_ready = 1'b0;
    check("t3_tagv", o_tag_valid, 1);
    tick(1);

    // Core never returns ciphertext
    start_op(64'd0, 64'd128, 128'd0, 96'd0);
    check("t4_err_cleared", o_error, 0);
    tick(18);
    send_blk(128'h5, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    seen_ct = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick(1);
      seen_ct |= o_ct_valid;
    end
    check("t4_err_before", o_error, 0);
    check("t4_busy_before", o_busy, 1);
    tick(1);
    seen_ct |= o_ct_valid;
    check("t4_err_timeout", o_error, 1);
    check("t4_busy_after", o_busy, 0);
    check("t4_no_ct", seen_ct, 0);
    tick(1);

    // Plaintext block offered during the AAD phase
    start_op(64'd256, 64'd128, 128'd0, 96'd0);
    check("t5a_err_cleared", o_error, 0);
    send_blk(128'hA0, 1'b1);
    tick(1); blk_if.i_blk_valid = 1'b0;
    tick(3);
    check("t5a_rdy_aad", blk_if.o_blk_ready, 1);
    send_blk(128'hEE, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check("t5a_err", o_error, 1);
    check("t5a_busy", o_busy, 0);
    tick(1);

    // One-cycle gap in the AAD stream
    start_op(64'd256, 64'd128, 128'd0, 96'd0);
    check("t5b_err_cleared", o_error, 0);
    send_blk(128'hA0, 1'b1);
    tick(1); blk_if.i_blk_valid = 1'b0;
    tick(3);
    tick(1);
    check("t5b_err", o_error, 1);
    check("t5b_busy", o_busy, 0);
    tick(1);

    // Asynchronous reset while waiting for ciphertext
    start_op(64'd0, 64'd128, 128'hFEED, 96'hBEEF);
    tick(18);
    send_blk(128'h9, 1'b0);
    tick(1); blk_if.i_blk_valid = 1'b0;
    check("t6_in_cpw", o_pt_instance, 1);
    tick(1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async_reset");
    tick(1);
    check_all_zero("t6_reset_held");
    rst_n = 1'b1;
    tick(1);
    run_single("t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
